booth_r4_mult: RTL

Parametrised radix-4 (modified Booth) sequential multiplier: accepts two W-bit operands in parallel on a start pulse, retires one Booth digit (2 multiplier bits) per clock, and returns a 2W-bit product with a one-cycle done pulse. It is the generalised successor of our fixed 8-bit serial-load Booth unit. It adds a width parameter, runtime signed/unsigned selection, and a start/busy/done handshake, so datapath blocks can share it as a multicycle arithmetic resource.

---
 rtl/booth_r4_mult.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/booth_r4_mult.sv
// Radix-4 (modified Booth) sequential multiplier with a start/busy/done handshake.
// Retires one Booth digit per clock on operands extended to W+2 bits.
module booth_r4_mult #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   product,
  output logic             busy,
  output logic             done
);

  localparam int E     = W + 2;
  localparam int AW    = E + 2;
  localparam int STEPS = E / 2;
  localparam int CW    = $clog2(STEPS);
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  if (((W % 2) != 0) || (W < 4)) begin : g_bad_width
    $error("booth_r4_mult: W must be even and >= 4");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                load_s;
  logic                finish_s;

  logic [E-1:0]        m_r;
  logic [E-1:0]        q_r;
  logic                q1_r;
  logic [AW-1:0]       acc_r;
  logic [CW-1:0]       cnt_r;
  logic [2*W-1:0]      product_r;
  logic                done_r;

  logic [AW-1:0]       m_ext_s;
  logic [AW-1:0]       m2_s;
  logic [AW-1:0]       addend_s;
  logic [AW-1:0]       sum_s;
  logic [AW-1:0]       acc_sh_s;
  logic [E-1:0]        q_sh_s;
  logic [2*W-1:0]      prod_sh_s;

  // Two extra bits keep both the unsigned range and the -2M digit representable.
  function automatic logic [E-1:0] extend(input logic [W-1:0] v, input logic sgn);
    logic [E-1:0] r;
    if (sgn) begin
      r = {{2{v[W-1]}}, v};
    end else begin
      r = {2'b00, v};
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; completion returns straight to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = ST_IDLE;
          finish_s    = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign m_ext_s = {{2{m_r[E-1]}}, m_r};
  assign m2_s    = {m_r[E-1], m_r, 1'b0};

  // Booth digit selection from the two low multiplier bits and the implicit bit.
  always_comb begin
    addend_s = '0;
    case ({q_r[1:0], q1_r})
      3'b001, 3'b010: addend_s = m_ext_s;
      3'b011:         addend_s = m2_s;
      3'b100:         addend_s = -m2_s;
      3'b101, 3'b110: addend_s = -m_ext_s;
      default:        addend_s = '0;
    endcase
  end

  assign sum_s     = acc_r + addend_s;
  assign acc_sh_s  = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
  assign q_sh_s    = {sum_s[1:0], q_r[E-1:2]};
  assign prod_sh_s = {acc_sh_s[W-3:0], q_sh_s};

  // Operand load, per-digit accumulate/shift and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_r       <= '0;
      q_r       <= '0;
      q1_r      <= 1'b0;
      acc_r     <= '0;
      cnt_r     <= '0;
      product_r <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (load_s) begin
        m_r   <= extend(a, signed_mode);
        q_r   <= extend(b, signed_mode);
        q1_r  <= 1'b0;
        acc_r <= '0;
        cnt_r <= '0;
      end else if (state_r == ST_RUN) begin
        acc_r <= acc_sh_s;
        q_r   <= q_sh_s;
        q1_r  <= q_r[1];
        if (finish_s) begin
          cnt_r     <= '0;
          product_r <= prod_sh_s;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  end

  assign busy    = (state_r == ST_RUN);
  assign done    = done_r;
  assign product = product_r;

endmodule
